// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// -----------------
// A bank of NCH independent event counters with a shadow (snapshot) bank,
// sticky per-channel overflow flags and a registered readout port.
//
// Parameters
//   NCH   : number of counter channels (1..16)
//   WIDTH : width of each counter and of rd_data (8..32)
//   SAT   : 0 = counters wrap to 0 on overflow, 1 = counters stick at max
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   in_RST     : synchronous active-high reset (clears everything)
//   en         : global count enable
//   ev         : per-channel event strobes, one increment per cycle each
//   clr        : clears live counters, overflow flags and snap_valid
//   freeze     : holds all live counters while high
//   snap       : copies the pre-edge live counters into the shadow bank
//   rd_snap    : readout source, 0 = live bank, 1 = shadow bank
//   sel        : readout channel index (values >= NCH read as 0)
//   rd_data    : registered readout, one cycle after sel/rd_snap
//   snap_valid : shadow bank holds a captured snapshot
//   ovf        : sticky per-channel overflow flags
module perf_counter_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             in_RST,
    input  logic             en,
    input  logic [NCH-1:0]   ev,
    input  logic             clr,
    input  logic             freeze,
    input  logic             snap,
    input  logic             rd_snap,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             snap_valid,
    output logic [NCH-1:0]   ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] live_q   [NCH];
    logic [WIDTH-1:0] live_d   [NCH];
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic             snap_valid_q;
    logic             snap_valid_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        live_d       = live_q;
        shadow_d     = shadow_q;
        ovf_d        = ovf_q;
        snap_valid_d = snap_valid_q;
        rd_data_d    = '0;

        // Readout looks at pre-edge state only, so an incrementing channel
        // reads back its old value. An index with no matching channel
        // leaves the default of 0.
        for (int i = 0; i < NCH; i++) begin
            if (sel == 4'(i)) begin
                if (rd_snap) begin
                    rd_data_d = snap_valid_q ? shadow_q[i] : '0;
                end else begin
                    rd_data_d = live_q[i];
                end
            end
        end

        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                live_d[i] = '0;
            end
            ovf_d        = '0;
            snap_valid_d = 1'b0;
        end else if (!freeze && en) begin
            for (int i = 0; i < NCH; i++) begin
                if (ev[i]) begin
                    if (live_q[i] == MAX_VAL) begin
                        ovf_d[i]  = 1'b1;
                        live_d[i] = SAT ? MAX_VAL : '0;
                    end else begin
                        live_d[i] = live_q[i] + WIDTH'(1);
                    end
                end
            end
        end

        // Capture is independent of clr/freeze and takes the pre-edge
        // values; it also wins over clr for snap_valid.
        if (snap) begin
            shadow_d     = live_q;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_RST) begin
            for (int i = 0; i < NCH; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            live_q       <= live_d;
            shadow_q     <= shadow_d;
            ovf_q        <= ovf_d;
            snap_valid_q <= snap_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign snap_valid = snap_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two instances (wrap and saturate, NCH=4,
// WIDTH=8) share one set of inputs. A counting model checks both every
// cycle; a vector table and directed sequences add fixed expectations.
module tb_perf_counter_bank;

    localparam int NCH  = 4;
    localparam int MAXV = 255;

    logic       clk;
    logic       in_rst;
    logic       en;
    logic [3:0] ev;
    logic       clr;
    logic       freeze;
    logic       snap;
    logic       rd_snap;
    logic [3:0] sel;

    logic [7:0] rd0, rd1;
    logic       sv0, sv1;
    logic [3:0] ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    perf_counter_bank #(.NCH(NCH), .WIDTH(8), .SAT(1'b0)) dut_wrap (
        .clk(clk), .in_RST(in_rst), .en(en), .ev(ev), .clr(clr),
        .freeze(freeze), .snap(snap), .rd_snap(rd_snap), .sel(sel),
        .rd_data(rd0), .snap_valid(sv0), .ovf(ovf0)
    );

    perf_counter_bank #(.NCH(NCH), .WIDTH(8), .SAT(1'b1)) dut_sat (
        .clk(clk), .in_RST(in_rst), .en(en), .ev(ev), .clr(clr),
        .freeze(freeze), .snap(snap), .rd_snap(rd_snap), .sel(sel),
        .rd_data(rd1), .snap_valid(sv1), .ovf(ovf1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Index 0 = wrap instance, 1 = saturate instance. Counts are plain
    // integers; overflow is "count would exceed 255".
    int m_live   [2][NCH];
    int m_shadow [2][NCH];
    bit m_ovf    [2][NCH];
    bit m_sv     [2];
    int m_rd     [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                m_live[m][c] = 0; m_shadow[m][c] = 0; m_ovf[m][c] = 0;
            end
            m_sv[m] = 0; m_rd[m] = 0;
        end
    end

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (in_rst) begin
                for (int c = 0; c < NCH; c++) begin
                    m_live[m][c] = 0; m_shadow[m][c] = 0; m_ovf[m][c] = 0;
                end
                m_sv[m] = 0;
                m_rd[m] = 0;
            end else begin
                int s;
                s = int'(sel);
                if (s >= NCH)        m_rd[m] = 0;
                else if (!rd_snap)   m_rd[m] = m_live[m][s];
                else                 m_rd[m] = m_sv[m] ? m_shadow[m][s] : 0;
                if (snap) begin
                    for (int c = 0; c < NCH; c++) m_shadow[m][c] = m_live[m][c];
                end
                m_sv[m] = snap ? 1'b1 : (clr ? 1'b0 : m_sv[m]);
                for (int c = 0; c < NCH; c++) begin
                    if (clr) begin
                        m_live[m][c] = 0;
                        m_ovf[m][c]  = 0;
                    end else if (en && ev[c] && !freeze) begin
                        if (m_live[m][c] + 1 > MAXV) begin
                            m_ovf[m][c]  = 1;
                            m_live[m][c] = (m == 1) ? MAXV : 0;
                        end else begin
                            m_live[m][c] = m_live[m][c] + 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [3:0] model_ovf(int m);
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_ovf[m][c];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: advance model on the edge, compare 1 time unit later.
    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, " rd wrap"},   int'(rd0),  m_rd[0]);
        check({tag, " ovf wrap"},  int'(ovf0), int'(model_ovf(0)));
        check({tag, " sv wrap"},   int'(sv0),  int'(m_sv[0]));
        check({tag, " rd sat"},    int'(rd1),  m_rd[1]);
        check({tag, " ovf sat"},   int'(ovf1), int'(model_ovf(1)));
        check({tag, " sv sat"},    int'(sv1),  int'(m_sv[1]));
    endtask

    // ---------------- driver ----------------
    task automatic set_idle();
        in_rst = 1'b0; en = 1'b0; ev = 4'b0; clr = 1'b0; freeze = 1'b0;
        snap = 1'b0; rd_snap = 1'b0; sel = 4'd0;
    endtask

    typedef struct {
        int         rep;
        bit         rst;
        bit         en;
        logic [3:0] ev;
        bit         clr;
        bit         frz;
        bit         snap;
        bit         rsnap;
        logic [3:0] sel;
        int         exp_rd;
        logic [3:0] exp_ovf;
        bit         exp_sv;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(int rep, bit rst, bit e, logic [3:0] evv,
                                    bit c, bit f, bit s, bit rs, logic [3:0] sl,
                                    int rd, logic [3:0] ov, bit sv);
        vec_t v;
        v.rep = rep; v.rst = rst; v.en = e; v.ev = evv; v.clr = c; v.frz = f;
        v.snap = s; v.rsnap = rs; v.sel = sl; v.exp_rd = rd; v.exp_ovf = ov;
        v.exp_sv = sv;
        vecs.push_back(v);
    endfunction

    // ---------------- test ----------------
    initial begin
        //          rep rst en ev       clr frz snp rsn sel   rd  ovf     sv
        add_vec(10, 0, 1, 4'b0101, 0, 0, 0, 0, 4'd0,  9, 4'b0, 0); // count ch0/ch2
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd0, 10, 4'b0, 0);
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd1,  0, 4'b0, 0);
        add_vec( 7, 0, 1, 4'b0010, 0, 0, 0, 0, 4'd1,  6, 4'b0, 0); // ch1 -> 7
        add_vec( 1, 0, 1, 4'b0010, 0, 0, 1, 0, 4'd1,  7, 4'b0, 1); // snap + event
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 1, 4'd1,  7, 4'b0, 1); // shadow ch1
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd1,  8, 4'b0, 1); // live ch1
        add_vec(20, 0, 1, 4'b1000, 0, 0, 0, 0, 4'd3, 19, 4'b0, 1); // ch3 -> 20
        add_vec( 1, 0, 0, 4'b0000, 1, 0, 1, 0, 4'd3, 20, 4'b0, 1); // clr + snap
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 1, 4'd3, 20, 4'b0, 1);
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd3,  0, 4'b0, 1);
        add_vec( 5, 0, 1, 4'b1111, 0, 1, 0, 0, 4'd3,  0, 4'b0, 1); // frozen
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd3,  0, 4'b0, 1);
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 1, 4'd0, 10, 4'b0, 1);
        add_vec( 3, 0, 1, 4'b1111, 0, 0, 0, 0, 4'd2,  2, 4'b0, 1); // all -> 3
        add_vec( 1, 1, 1, 4'b1111, 0, 0, 1, 0, 4'd2,  0, 4'b0, 0); // rst + snap
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 1, 4'd1,  0, 4'b0, 0); // no snapshot
        add_vec( 1, 0, 1, 4'b1111, 0, 0, 0, 0, 4'd5,  0, 4'b0, 0); // sel >= NCH
        add_vec( 1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'd0,  1, 4'b0, 0); // first count

        // reset state
        set_idle();
        in_rst = 1'b1;
        repeat (2) tick("reset");
        check("reset rd",   int'(rd0),  0);
        check("reset ovf",  int'(ovf0), 0);
        check("reset sv",   int'(sv0),  0);
        in_rst = 1'b0;

        // table vectors
        foreach (vecs[k]) begin
            in_rst = vecs[k].rst; en = vecs[k].en; ev = vecs[k].ev;
            clr = vecs[k].clr; freeze = vecs[k].frz; snap = vecs[k].snap;
            rd_snap = vecs[k].rsnap; sel = vecs[k].sel;
            repeat (vecs[k].rep) tick("vec");
            check($sformatf("vec%0d rd", k),  int'(rd0),  vecs[k].exp_rd);
            check($sformatf("vec%0d ovf", k), int'(ovf0), int'(vecs[k].exp_ovf));
            check($sformatf("vec%0d sv", k),  int'(sv0),  int'(vecs[k].exp_sv));
        end

        // wrap / saturate on ch2
        set_idle(); in_rst = 1'b1; tick("wrap rst"); in_rst = 1'b0;
        sel = 4'd2; en = 1'b1; ev = 4'b0100;
        repeat (255) tick("wrap fill");
        en = 1'b0; tick("wrap rd255");
        check("wrap at max rd",  int'(rd0),  255);
        check("wrap at max ovf", int'(ovf0), 0);
        en = 1'b1; tick("wrap edge");
        check("wrap edge ovf",   int'(ovf0), 4'b0100);
        check("sat edge ovf",    int'(ovf1), 4'b0100);
        en = 1'b0; tick("wrap rd0");
        check("wrap to zero",    int'(rd0),  0);
        check("sat hold max",    int'(rd1),  255);
        en = 1'b1; repeat (3) tick("wrap more");
        en = 1'b0; tick("wrap rd3");
        check("wrap count 3",    int'(rd0),  3);
        check("wrap ovf sticky", int'(ovf0), 4'b0100);
        clr = 1'b1; tick("wrap clr"); clr = 1'b0;
        check("clr ovf wrap",    int'(ovf0), 0);
        check("clr ovf sat",     int'(ovf1), 0);

        // 300 events on ch0
        sel = 4'd0; en = 1'b1; ev = 4'b0001;
        repeat (300) tick("sat fill");
        en = 1'b0; tick("sat rd");
        check("sat 300 rd",  int'(rd1),  255);
        check("sat 300 ovf", int'(ovf1), 4'b0001);
        check("wrap 300 rd", int'(rd0),  44);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_rst  = ($urandom_range(0, 99) == 0);
            en      = ($urandom_range(0, 3) != 0);
            ev      = 4'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 40) == 0);
            freeze  = ($urandom_range(0, 7) == 0);
            snap    = ($urandom_range(0, 9) == 0);
            rd_snap = 1'($urandom_range(0, 1));
            sel     = 4'($urandom_range(0, 7));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
